// File: rtl/cpu_stage_seq.sv
// cpu_stage_seq: stage sequencer with auto/manual stepping, PC breakpoint and retired-instruction counter
module cpu_stage_seq #(
    parameter int NUM_STAGES = 5,
    parameter int STAGE_W    = 3,
    parameter int ADDR_W     = 8,
    parameter int AUTO_DIV   = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              isAuto,
    input  logic              nextStage,
    input  logic              bpEn,
    input  logic [ADDR_W-1:0] bpAddr,
    input  logic [ADDR_W-1:0] pcAddr,
    output logic [STAGE_W-1:0] stage,
    output logic              stageEn,
    output logic              instrDone,
    output logic              halted,
    output logic [CNT_W-1:0]  instrCount
);
    localparam int DIV_W = AUTO_DIV > 1 ? $clog2(AUTO_DIV) : 1;
    localparam logic [STAGE_W-1:0] LAST = STAGE_W'(NUM_STAGES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(AUTO_DIV - 1);
    typedef enum logic [1:0] {RUN, STEP, BRK} state_t;
    state_t state;
    logic [DIV_W-1:0] div;
    logic next_prev, step_edge, wrap, adv, bp_hit;
    always_comb begin
        step_edge = nextStage & ~next_prev;
        wrap = stage == LAST;
        adv = state == RUN ? (isAuto && div == DIV_LAST) : (state == STEP && !isAuto && step_edge);
        bp_hit = state == RUN && adv && wrap && bpEn && pcAddr == bpAddr;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= isAuto ? RUN : STEP;
            stage <= '0;
            div <= '0;
            stageEn <= 1'b0;
            instrDone <= 1'b0;
            halted <= 1'b0;
            instrCount <= '0;
            next_prev <= 1'b1;
        end else begin
            next_prev <= nextStage;
            stageEn <= adv;
            instrDone <= adv && wrap;
            if (adv) stage <= wrap ? '0 : stage + 1'b1;
            if (adv && wrap && !(&instrCount)) instrCount <= instrCount + 1'b1;
            case (state)
                RUN: begin
                    div <= (!isAuto || adv) ? '0 : div + 1'b1;
                    state <= !isAuto ? STEP : bp_hit ? BRK : RUN;
                    halted <= bp_hit;
                end
                STEP: if (isAuto) begin
                    state <= RUN;
                    div <= '0;
                end
                // leaving BRK: a mode drop wins over a resume request
                BRK: if (!isAuto || step_edge) begin
                    state <= isAuto ? RUN : STEP;
                    div <= '0;
                    halted <= 1'b0;
                end
                default: state <= isAuto ? RUN : STEP;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_stage_seq.sv
// tb_cpu_stage_seq: directed checks of auto/manual stepping, breakpoint, saturation and reset
module tb_cpu_stage_seq;
    logic clk = 0, rst = 1, isAuto = 1, nextStage = 0, bpEn = 0;
    logic [7:0] bpAddr = 8'h12, pcAddr = 8'h00;
    logic [2:0] s1, s3, sc;
    logic e1, e3, ec, d1, d3, dc, h1, h3, hc;
    logic [15:0] c1, c3;
    logic [2:0] cc;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    cpu_stage_seq u1 (.clk(clk), .rst(rst), .isAuto(isAuto), .nextStage(nextStage), .bpEn(bpEn),
        .bpAddr(bpAddr), .pcAddr(pcAddr), .stage(s1), .stageEn(e1), .instrDone(d1), .halted(h1), .instrCount(c1));
    cpu_stage_seq #(.AUTO_DIV(3)) u3 (.clk(clk), .rst(rst), .isAuto(isAuto), .nextStage(nextStage), .bpEn(bpEn),
        .bpAddr(bpAddr), .pcAddr(pcAddr), .stage(s3), .stageEn(e3), .instrDone(d3), .halted(h3), .instrCount(c3));
    cpu_stage_seq #(.CNT_W(3)) uc (.clk(clk), .rst(rst), .isAuto(isAuto), .nextStage(nextStage), .bpEn(bpEn),
        .bpAddr(bpAddr), .pcAddr(pcAddr), .stage(sc), .stageEn(ec), .instrDone(dc), .halted(hc), .instrCount(cc));

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic auto_mode);
        isAuto = auto_mode;
        rst = 1;
        tick(2);
        rst = 0;
    endtask

    task automatic test_reset;
        nextStage = 0;
        bpEn = 0;
        isAuto = 1;
        rst = 1;
        tick(2);
        n_cmp++; if (s1 !== 3'd0) begin n_err++; $display("FAIL reset_stage got=%0d exp=0", s1); end
        n_cmp++; if ({e1, d1, h1} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b exp=000", {e1, d1, h1}); end
        n_cmp++; if (c1 !== 16'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", c1); end
        rst = 0;
    endtask

    task automatic test_auto_div1;
        do_reset(1);
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_cmp++; if (s1 !== 3'(i % 5)) begin n_err++; $display("FAIL div1_stage[%0d] got=%0d exp=%0d", i, s1, i % 5); end
            n_cmp++; if (e1 !== 1'b1) begin n_err++; $display("FAIL div1_stageEn[%0d] got=%b exp=1", i, e1); end
            n_cmp++; if (d1 !== (i % 5 == 0)) begin n_err++; $display("FAIL div1_instrDone[%0d] got=%b exp=%b", i, d1, i % 5 == 0); end
        end
        n_cmp++; if (c1 !== 16'd2) begin n_err++; $display("FAIL div1_count got=%0d exp=2", c1); end
    endtask

    task automatic test_auto_div3;
        do_reset(1);
        for (int i = 1; i <= 9; i++) begin
            tick();
            n_cmp++; if (s3 !== 3'(i / 3)) begin n_err++; $display("FAIL div3_stage[%0d] got=%0d exp=%0d", i, s3, i / 3); end
            n_cmp++; if (e3 !== (i % 3 == 0)) begin n_err++; $display("FAIL div3_stageEn[%0d] got=%b exp=%b", i, e3, i % 3 == 0); end
        end
        tick();
        isAuto = 0;
        tick();
        n_cmp++; if ({s3, e3} !== {3'd3, 1'b0}) begin n_err++; $display("FAIL div3_to_step got=%0d/%b exp=3/0", s3, e3); end
        isAuto = 1;
        tick(3);
        n_cmp++; if (s3 !== 3'd3) begin n_err++; $display("FAIL div3_restart_hold got=%0d exp=3", s3); end
        tick();
        n_cmp++; if ({s3, e3} !== {3'd4, 1'b1}) begin n_err++; $display("FAIL div3_restart_adv got=%0d/%b exp=4/1", s3, e3); end
    endtask

    task automatic test_manual;
        int lens[3] = '{1, 4, 10};
        nextStage = 1;
        do_reset(0);
        tick(3);
        n_cmp++; if ({s1, e1} !== {3'd0, 1'b0}) begin n_err++; $display("FAIL manual_held_reset got=%0d/%b exp=0/0", s1, e1); end
        nextStage = 0;
        tick();
        for (int p = 0; p < 3; p++) begin
            nextStage = 1;
            tick();
            n_cmp++; if ({s1, e1} !== {3'(p + 1), 1'b1}) begin n_err++; $display("FAIL manual_edge[%0d] got=%0d/%b exp=%0d/1", p, s1, e1, p + 1); end
            tick(lens[p]);
            nextStage = 0;
            n_cmp++; if ({s1, e1} !== {3'(p + 1), 1'b0}) begin n_err++; $display("FAIL manual_held[%0d] got=%0d/%b exp=%0d/0", p, s1, e1, p + 1); end
            tick();
        end
        n_cmp++; if (s1 !== 3'd3) begin n_err++; $display("FAIL manual_total got=%0d exp=3", s1); end
    endtask

    task automatic test_breakpoint;
        nextStage = 0;
        bpEn = 1;
        bpAddr = 8'h12;
        pcAddr = 8'h12;
        do_reset(1);
        tick(4);
        n_cmp++; if ({s1, h1} !== {3'd4, 1'b0}) begin n_err++; $display("FAIL bp_before got=%0d/%b exp=4/0", s1, h1); end
        tick();
        n_cmp++; if ({s1, h1, d1} !== {3'd0, 1'b1, 1'b1}) begin n_err++; $display("FAIL bp_hit got=%0d/%b/%b exp=0/1/1", s1, h1, d1); end
        tick(20);
        n_cmp++; if ({s1, h1, e1} !== {3'd0, 1'b1, 1'b0}) begin n_err++; $display("FAIL bp_hold got=%0d/%b/%b exp=0/1/0", s1, h1, e1); end
        pcAddr = 8'h20;
        nextStage = 1;
        tick();
        n_cmp++; if ({s1, h1} !== {3'd0, 1'b0}) begin n_err++; $display("FAIL bp_resume got=%0d/%b exp=0/0", s1, h1); end
        nextStage = 0;
        tick();
        n_cmp++; if ({s1, e1} !== {3'd1, 1'b1}) begin n_err++; $display("FAIL bp_after got=%0d/%b exp=1/1", s1, e1); end
        bpEn = 0;
    endtask

    task automatic test_saturate;
        do_reset(1);
        tick(30);
        n_cmp++; if (cc !== 3'd6) begin n_err++; $display("FAIL sat_6 got=%0d exp=6", cc); end
        tick(5);
        n_cmp++; if (cc !== 3'd7) begin n_err++; $display("FAIL sat_7 got=%0d exp=7", cc); end
        tick(10);
        n_cmp++; if (cc !== 3'd7) begin n_err++; $display("FAIL sat_hold got=%0d exp=7", cc); end
    endtask

    task automatic test_reset_mid;
        do_reset(1);
        tick(8);
        n_cmp++; if ({s1, c1} !== {3'd3, 16'd1}) begin n_err++; $display("FAIL mid_pre got=%0d/%0d exp=3/1", s1, c1); end
        rst = 1;
        tick();
        n_cmp++; if ({s1, e1, d1, h1, c1} !== {3'd0, 3'b000, 16'd0}) begin n_err++; $display("FAIL mid_reset got=%0d/%b/%b/%b/%0d exp=0/0/0/0/0", s1, e1, d1, h1, c1); end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_auto_div1();
        test_auto_div3();
        test_manual();
        test_breakpoint();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
